// File: rtl/load_store_controller.sv
`default_nettype none
// ============================================================================
// Module      : load_store_controller
// Description : Sequences byte/halfword/word loads and stores between the
//               execute stage and a fixed-latency data memory. Stores drive
//               byte-lane enables with lane-replicated data. Loads wait the
//               memory latency, pick the addressed lane and extend it to 32
//               bits. Misaligned or illegal accesses are answered with an
//               error response and never reach memory.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_controller #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STORE     = 3'd1,
    ST_LOAD_WAIT = 3'd2,
    ST_RESP      = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

  // Latency counter loads this value on acceptance and counts down to zero.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic                mem_en_q, mem_en_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;

  logic                misaligned;
  logic [3:0]          store_we;
  logic [31:0]         store_wdata;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [31:0]         load_ext;

  // Alignment rule: halfwords need an even address, words a 4-byte boundary.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Byte-lane enables and replicated store data from the incoming request.
  always_comb begin
    store_we    = 4'b1111;
    store_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        store_we    = 4'b0001 << req_addr[1:0];
        store_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        store_we    = req_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        store_we    = 4'b1111;
        store_wdata = req_wdata;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returning read data.
  always_comb begin
    case (lane_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{signed_q & load_half[15]}}, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    signed_d    = signed_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lane_d   = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          if (misaligned) begin
            // Error response goes out next cycle; memory is left untouched.
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write) begin
              state_d     = ST_STORE;
              mem_we_d    = store_we;
              mem_wdata_d = store_wdata;
            end else begin
              state_d = ST_LOAD_WAIT;
              cnt_d   = LAT_INIT;
            end
          end
        end
      end
      ST_STORE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'd0;
      end
      ST_LOAD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_load_store_controller
// Description : Randomized and directed bench for load_store_controller with a
//               byte-addressed reference memory and a fixed-latency memory
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_controller;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_error, busy;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  load_store_controller #(.MEM_LATENCY(L), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73 + 29) & 255);
  endfunction

  // ---------------- memory responder: data valid L cycles after mem_en ----
  logic [31:0] phys [64];
  logic        pv [L];
  logic [31:0] pd [L];
  logic [31:0] junk;
  logic        phys_init = 1'b0;

  always @(posedge clk) begin
    if (!phys_init) begin
      for (int w = 0; w < 64; w++)
        phys[w] <= {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
      phys_init <= 1'b1;
    end else if (mem_en && mem_we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) phys[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pv[0] <= mem_en && (mem_we == 4'b0000);
    pd[0] <= phys[mem_addr[7:2]];
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    junk <= $urandom;
  end

  assign mem_rdata = pv[L-1] ? pd[L-1] : junk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] exp_rd;
    int          acc;
    int          lat;
  } txn_t;

  logic [7:0]  ref_mem [256];
  bit          ref_init = 1'b0;
  txn_t        q[$];
  int          acc_log[$];
  txn_t        t;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          en_cnt = 0;
  logic [31:0] last_rsp = 32'd0;
  logic [31:0] last_rdata, st_we, st_wd, st_addr;
  int          last_lat, last_en;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int k = 0; k < n; k++) v |= 32'(ref_mem[(addr + k) & 255]) << (8*k);
    if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
    return v;
  endfunction

  function automatic logic [31:0] exp_we(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    n = 1 << sz;
    return 32'((((1 << n) - 1) << (addr % 4)) & 15);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
    return v;
  endfunction

  // Observe the DUT away from the active edge and score every transaction.
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
      ref_init = 1'b1;
    end
    if (rst) begin
      q.delete();
      last_rsp = 32'd0;
    end else begin
      check_eq("busy", busy, q.size() != 0);
      check_eq("req_ready", req_ready, q.size() == 0);
      if (mem_en) begin
        if (q.size() == 0) check_eq("stray_mem_en", mem_en, 1'b0);
        else begin
          en_cnt++;
          check_eq("mem_addr", mem_addr, {q[0].addr[31:2], 2'b00});
          check_eq("mem_we", mem_we, q[0].wr ? exp_we(q[0].sz, q[0].addr) : 32'd0);
          if (q[0].wr) check_eq("mem_wdata", mem_wdata, exp_wd(q[0].sz, q[0].wd));
          st_we = mem_we; st_wd = mem_wdata; st_addr = mem_addr;
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) check_eq("unexpected_rsp", rsp_valid, 1'b0);
        else begin
          t = q.pop_front();
          check_eq("rsp_latency", cyc - t.acc, t.lat);
          check_eq("rsp_error", rsp_error, t.err);
          check_eq("rsp_rdata", rsp_rdata, t.exp_rd);
          check_eq("mem_en_count", en_cnt, t.err ? 0 : 1);
          last_rdata = rsp_rdata; last_err = rsp_error;
          last_lat = cyc - t.acc; last_en = en_cnt;
          last_rsp = rsp_rdata;
          rsp_cnt++;
        end
      end else begin
        check_eq("rdata_hold", rsp_rdata, last_rsp);
      end
      if (req_valid && req_ready) begin
        t.wr = req_write; t.sz = req_size; t.sg = req_signed;
        t.addr = req_addr; t.wd = req_wdata; t.acc = cyc;
        t.err = (req_size == 2'b11) || ((req_addr % (1 << req_size)) != 0);
        if (t.err) begin
          t.exp_rd = 32'd0; t.lat = 1;
        end else if (t.wr) begin
          for (int k = 0; k < (1 << t.sz); k++) ref_mem[(t.addr + k) & 255] = t.wd[8*k +: 8];
          t.exp_rd = 32'd0; t.lat = 2;
        end else begin
          t.exp_rd = ref_load(t.sz, t.sg, t.addr); t.lat = L + 2;
        end
        q.push_back(t);
        acc_log.push_back(cyc);
        en_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Call only at #1 after a rising edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input bit wait_rsp);
    bit acc;
    bit got;
    int target;
    acc = 1'b0; got = 1'b0;
    target = rsp_cnt + 1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("accept_timeout", acc, 1'b1);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (wait_rsp) begin
      for (int i = 0; i < 30 && !got; i++) begin
        @(posedge clk); #1;
        if (rsp_cnt >= target) got = 1'b1;
      end
      check_eq("rsp_timeout", got, 1'b1);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, req_ready, 1'b1);
    check_eq({tag, "_mem_en"}, mem_en, 1'b0);
    check_eq({tag, "_mem_we"}, mem_we, 4'b0000);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_error"}, rsp_error, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_err_rsp(input string tag);
    check_eq({tag, "_err"}, last_err, 1'b1);
    check_eq({tag, "_rdata"}, last_rdata, 32'd0);
    check_eq({tag, "_lat"}, last_lat, 1);
    check_eq({tag, "_mem_en"}, last_en, 0);
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] sz, input bit allow_mis);
    logic [31:0] a;
    a = $urandom;
    if (!allow_mis) begin
      if (sz == 2'b01) a[0] = 1'b0;
      else if (sz != 2'b00) a[1:0] = 2'b00;
    end
    return a;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, target;
    bit got;
    logic [1:0] sz;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;

    // Loads with sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h80AB_CDEF, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 1'b1);
    check_eq("lb_rdata", last_rdata, 32'hFFFF_FF80);
    check_eq("lb_err", last_err, 1'b0);
    check_eq("lb_lat", last_lat, L + 2);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1'b1);
    check_eq("lbu_rdata", last_rdata, 32'h0000_0080);
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h8001_1234, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 1'b1);
    check_eq("lh_rdata", last_rdata, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'd0, 1'b1);
    check_eq("lhu_rdata", last_rdata, 32'h0000_1234);

    // Stores: lane enables and replication
    issue(1'b1, 2'b00, 1'b0, 32'h06, 32'h1234_56AA, 1'b1);
    check_eq("sb_we", st_we, 32'h4);
    check_eq("sb_wdata", st_wd, 32'hAAAA_AAAA);
    check_eq("sb_addr", st_addr, 32'h4);
    check_eq("sb_en", last_en, 1);
    check_eq("sb_lat", last_lat, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h02, 32'h0000_BEEF, 1'b1);
    check_eq("sh_we", st_we, 32'hC);
    check_eq("sh_wdata", st_wd, 32'hBEEF_BEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFE_F00D, 1'b1);
    check_eq("sw_we", st_we, 32'hF);
    check_eq("sw_wdata", st_wd, 32'hCAFE_F00D);

    // Misaligned and illegal
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1'b1);
    check_err_rsp("lw_mis");
    issue(1'b1, 2'b01, 1'b0, 32'h101, 32'h5555, 1'b1);
    check_err_rsp("sh_mis");
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'd0, 1'b1);
    check_err_rsp("size3");

    // Reset during LOAD_WAIT
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back loads with fields changing while busy
    a0 = acc_log.size();
    target = rsp_cnt + 4;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && acc_log.size() < a0 + 4; i++) begin
      sz = 2'($urandom_range(0, 2));
      req_write = 1'b0; req_size = sz; req_signed = 1'($urandom);
      req_addr = rand_addr(sz, 1'b0); req_wdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check_eq("b2b_count", acc_log.size() - a0, 4);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt >= target) got = 1'b1;
    end
    check_eq("b2b_rsp_timeout", got, 1'b1);
    for (int k = 1; k < 4 && a0 + k < acc_log.size(); k++)
      check_eq("b2b_gap", acc_log[a0+k] - acc_log[a0+k-1], L + 3);

    // Randomized mix of stores, loads and bad accesses
    for (int n = 0; n < 80; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), rand_addr(sz, $urandom_range(0, 6) == 0),
            $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Sequences every data-memory access from the core pipeline for byte, halfword and word loads and stores.
- On stores, generates byte-lane write enables and replicates the store data across lanes.
- On loads, waits a fixed memory read latency, selects the addressed byte or halfword lane and sign- or zero-extends it to 32 bits.
- Flags misaligned accesses without touching memory. Sits between the execute stage and the data memory (addr/di/do0/we).

Parameters:
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (1..7).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  core presents an access
- req_ready  out  1  controller accepts the access this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- req_signed  in  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU); ignored for word and stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write enables, bit i = byte lane i
- mem_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data (do0)
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  extended load result (0 for stores and errors)
- rsp_error  out  1  misaligned/illegal flag, qualified by rsp_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE; req_ready = 1; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rsp_valid = 0; rsp_rdata = 0; rsp_error = 0; busy = 0. Reset mid-access aborts it with no response pulse and mem_en/mem_we dropped in the next cycle.
- Handshake: accept when req_valid && req_ready. req_ready = 1 only in IDLE. Request fields are latched at acceptance; later changes are ignored. One access outstanding at most.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0; size 11 is always illegal.
- FSM states: IDLE, STORE, LOAD_WAIT, RESP, ERR.
- IDLE, accepted and misaligned/illegal -> ERR. No mem_en.
- IDLE, accepted store -> STORE.
- IDLE, accepted load -> LOAD_WAIT with latency counter = MEM_LATENCY.
- STORE: one cycle with mem_en = 1 and mem_we set.
  - byte: we = 1 << addr[1:0].
  - half: 0011 or 1100 per addr[1].
  - word: 1111.
  - mem_wdata: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
  - Next state RESP.
- LOAD_WAIT: mem_en = 1 on the first cycle only, mem_we = 0. Counter decrements each cycle. When it reaches 0, mem_rdata is sampled and extended, then -> RESP.
  - byte lane: mem_rdata[8*addr[1:0] +: 8].
  - half lane: mem_rdata[16*addr[1] +: 16].
  - Extension fills bits above the lane with the lane MSB if req_signed, else 0. Word passes through unchanged.
- RESP: rsp_valid = 1 and rsp_error = 0 for exactly one cycle, rsp_rdata = result (0 for stores) -> IDLE.
- ERR: rsp_valid = 1, rsp_error = 1, rsp_rdata = 0 for one cycle -> IDLE.
- rsp_rdata holds its value until the next response. rsp_valid and rsp_error are pulses.
- Latency from acceptance to rsp_valid:
  - store: 2 cycles.
  - load: MEM_LATENCY + 2 cycles.
  - error: 1 cycle.
- A new request is accepted the cycle after RESP/ERR, back-to-back with no bubble beyond IDLE.

Test Plan:
- Reset, then LB at addr 0x103 with mem_rdata = 0x80AB_CDEF, signed -> rsp_rdata = 0xFFFF_FF80, rsp_error = 0, rsp_valid asserted MEM_LATENCY + 2 cycles after acceptance.
- LBU at same address/data -> 0x0000_0080. LH at 0x102 signed with mem_rdata = 0x8001_1234 -> 0xFFFF_8001. LHU at 0x100 -> 0x0000_1234.
- SB at addr 0x06 with wdata 0x1234_56AA -> mem_we = 0100, mem_wdata = 0xAAAA_AAAA, mem_addr = 0x04, single mem_en cycle. SH at 0x02 -> we = 1100. SW at 0x08 -> we = 1111.
- LW at 0x102, SH at 0x101, and size 11 at 0x0 -> rsp_error = 1, rsp_rdata = 0, mem_en never asserted, response 1 cycle after acceptance.
- Assert rst during LOAD_WAIT (MEM_LATENCY = 3) -> next cycle all outputs at reset values, no rsp_valid, req_ready = 1.
- req_valid held high for 4 back-to-back loads with request fields changing while busy -> req_ready low while busy, each response matches the fields latched at its acceptance, no access dropped or duplicated.
